tpmem_sched: RTL and testbench
==============================

# tpmem_sched

Frame scheduler that shares the 6x6 transpose memory between two row-vector requesters, A and B. It arbitrates round-robin at frame granularity and accepts 6 row beats from the granted requester over a valid/ready handshake. It drives the memory's `i_data`/`i_enable` with the exact 8-beat load sequence, then holds enable low for the memory's 8-cycle column read-out. It also tags the column output stream with the owning requester.

## Interface
- `BW`, default 12: element width. Row beat = 6*BW, holding elements e0..e5 with e0 in the MSBs.
- `i_clk` in 1: clock.
- `i_Reset` in 1: reset, synchronous, active-low. Shared with the transpose memory.
- `i_a_valid` in 1: requester A beat valid.
- `i_a_data` in 6*BW: requester A row beat.
- `o_a_ready` out 1: requester A beat accepted when valid & ready.
- `i_b_valid` in 1: requester B beat valid.
- `i_b_data` in 6*BW: requester B row beat.
- `o_b_ready` out 1: requester B beat accepted when valid & ready.
- `o_mem_data` out 6*BW: to memory `i_data`. Registered.
- `o_mem_en` out 1: to memory `i_enable`. Registered.
- `o_col_owner` out 1: owner of the frame currently in column read-out (0 = A, 1 = B).
- `o_busy` out 1: high in every state except IDLE.
- `o_frame_done` out 1: one-cycle pulse on the last DRAIN cycle.
- `o_cnt_a` out 8: frames completed for A, wraps at 255 -> 0.
- `o_cnt_b` out 8: frames completed for B, wraps at 255 -> 0.

## Operation
- Memory contract:
  - The memory counter advances on each cycle with `i_enable` = 1 while in the row phase (0-7).
  - The first 6 enabled beats write rows 0-5. Beats 6 and 7 are padding.
  - Counts 8-15 advance automatically. Any enable during 8-15 corrupts columns, so `o_mem_en` must be 0 throughout.
- FSM states: IDLE, LOAD, PAD, DRAIN. Reset state is IDLE.
- IDLE:
  - If any valid is high, register the grant and go to LOAD.
  - With both valid, grant the requester not granted last. The last-granted pointer resets to B, so A wins the first tie.
  - With one valid, grant that one.
- LOAD:
  - `o_x_ready` = 1 for the granted requester only; the other ready is 0.
  - On each accept, next cycle: `o_mem_data` = beat, `o_mem_en` = 1. Otherwise `o_mem_en` = 0 and `o_mem_data` holds.
  - The beat counter runs 0-5. After accepting beat 5, go to PAD.
  - Valid gaps stall the sequence. The memory counter holds, and no timeout applies.
- PAD:
  - 2 cycles. Each produces `o_mem_en` = 1 with `o_mem_data` = 0 on the following cycle.
  - Then go to DRAIN and latch `o_col_owner` = grant.
- DRAIN:
  - 8 cycles with `o_mem_en` = 0.
  - On the last cycle, pulse `o_frame_done` and increment the owner's frame counter.
  - Update the pointer, then go to IDLE.
- Ready is 0 in IDLE, PAD and DRAIN. Inputs not granted are ignored, never dropped.
- Reset values:
  - State IDLE, pointer B.
  - `o_mem_en`, `o_mem_data`, `o_col_owner`, `o_frame_done`, `o_cnt_a`, `o_cnt_b` all 0.
  - Both readies 0, `o_busy` 0.
- Reset mid-frame returns to IDLE with no pending beats. The memory resets on the same edge, so both restart aligned.

## Timing
- The cycle numbering below assumes no stalls. Let cycle n be the accept of beat 5.
- `o_mem_en` schedule:
  - Beat 5 at n+1.
  - Pad beats at n+2 and n+3.
  - Low from n+4 onward.
- Memory columns occupy n+4..n+11. Memory `o_en` is high n+5..n+12.
- State schedule: PAD n+1..n+2, DRAIN n+3..n+10, IDLE n+11, LOAD from n+12.
- Next frame: first accept no earlier than n+12, with its `o_mem_en` at n+13. The memory counter returns to 0 at n+12.
- Minimum frame period is 17 cycles: 1 IDLE + 6 LOAD + 2 PAD + 8 DRAIN.
- `o_col_owner` changes only on PAD->DRAIN. It is therefore stable across the memory `o_en` window of its own frame.
- Grant-to-first-ready latency: 1 cycle (registered grant).

## Test plan
- Single frame from A, rows 0x001..0x006 replicated per element with valid held high:
  - `o_mem_en` pattern is 1×8 then 0×8.
  - Memory columns transpose correctly.
  - `o_col_owner` = 0, `o_cnt_a` = 1, `o_frame_done` pulses once at n+10.
- A and B valid continuously for 4 frames:
  - Grants run A, B, A, B; `o_cnt_a` = `o_cnt_b` = 2.
  - The period is exactly 17 cycles per frame.
  - The non-granted ready never rises.
- A drops valid for 3 cycles after beat 2:
  - `o_mem_en` = 0 for 3 cycles.
  - Memory output matches the unstalled case, and the frame completes 3 cycles later.
- B requests during A's DRAIN: `o_b_ready` stays 0 until the cycle after IDLE, and B's first `o_mem_en` is no earlier than the memory counter's return to 0.
- `i_Reset` = 0 during LOAD beat 3, then valid re-asserted:
  - All outputs return to reset values.
  - The next frame starts at beat 0, and the memory rows match the new data only.
- 256 A-only frames: `o_cnt_a` wraps to 0, `o_cnt_b` stays 0.

Source files
------------

// File: rtl/tpmem_sched.sv
// tpmem_sched: round-robin frame scheduler that feeds a 6x6 transpose memory.
// Takes 6 row beats from the granted requester, appends 2 zero pad beats, then
// keeps the memory enable low for the 8-cycle column read-out.
module tpmem_sched #(
  parameter int BW = 12
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic            i_a_valid,
  input  logic [6*BW-1:0] i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [6*BW-1:0] i_b_data,
  output logic            o_b_ready,
  output logic [6*BW-1:0] o_mem_data,
  output logic            o_mem_en,
  output logic            o_col_owner,
  output logic            o_busy,
  output logic            o_frame_done,
  output logic [7:0]      o_cnt_a,
  output logic [7:0]      o_cnt_b
);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DRAIN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      cnt;
  logic            grant;
  logic            last_grant;
  logic            grant_nxt;
  logic            any_valid;
  logic            accept;
  logic [6*BW-1:0] beat;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, arbitration and handshake decode; readies are masked while in reset
  always_comb begin
    state_nxt = state;
    any_valid = i_a_valid | i_b_valid;
    grant_nxt = (i_a_valid & i_b_valid) ? ~last_grant : i_b_valid;
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;
    if (i_Reset && (state == LOAD)) begin
      o_a_ready = ~grant;
      o_b_ready = grant;
    end
    accept = (o_a_ready & i_a_valid) | (o_b_ready & i_b_valid);
    beat   = grant ? i_b_data : i_a_data;
    o_busy = (state != IDLE);
    case (state)
      IDLE:    if (any_valid) state_nxt = LOAD;
      LOAD:    if (accept && (cnt == 3'd5)) state_nxt = PAD;
      PAD:     if (cnt == 3'd1) state_nxt = DRAIN;
      DRAIN:   if (cnt == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter, grant bookkeeping, memory drive and frame statistics
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      cnt          <= 3'd0;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      o_mem_data   <= '0;
      o_mem_en     <= 1'b0;
      o_col_owner  <= 1'b0;
      o_frame_done <= 1'b0;
      o_cnt_a      <= 8'd0;
      o_cnt_b      <= 8'd0;
    end else begin
      o_mem_en     <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (any_valid) grant <= grant_nxt;
        end
        LOAD: begin
          if (accept) begin
            o_mem_data <= beat;
            o_mem_en   <= 1'b1;
            cnt        <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
          end
        end
        PAD: begin
          o_mem_data <= '0;
          o_mem_en   <= 1'b1;
          if (cnt == 3'd1) begin
            cnt         <= 3'd0;
            o_col_owner <= grant;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DRAIN: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) o_frame_done <= 1'b1;
          if (cnt == 3'd7) begin
            cnt        <= 3'd0;
            last_grant <= grant;
            if (grant) o_cnt_b <= o_cnt_b + 8'd1;
            else       o_cnt_a <= o_cnt_a + 8'd1;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_tpmem_sched.sv
// tb_tpmem_sched: self-checking bench for tpmem_sched with a frame-level
// reference model and an observer of the downstream memory's row counter.
module tb_tpmem_sched;

  localparam int BW = 12;
  localparam int W  = 6 * BW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid;
  logic         b_valid;
  logic [W-1:0] a_data;
  logic [W-1:0] b_data;
  logic         a_ready;
  logic         b_ready;
  logic [W-1:0] mem_data;
  logic         mem_en;
  logic         col_owner;
  logic         busy;
  logic         frame_done;
  logic [7:0]   cnt_a;
  logic [7:0]   cnt_b;

  int checks   = 0;
  int failures = 0;

  tpmem_sched #(.BW(BW)) dut (
    .i_clk       (clk),
    .i_Reset     (rst_n),
    .i_a_valid   (a_valid),
    .i_a_data    (a_data),
    .o_a_ready   (a_ready),
    .i_b_valid   (b_valid),
    .i_b_data    (b_data),
    .o_b_ready   (b_ready),
    .o_mem_data  (mem_data),
    .o_mem_en    (mem_en),
    .o_col_owner (col_owner),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_cnt_a     (cnt_a),
    .o_cnt_b     (cnt_b)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Pending beats per requester; the head is what the requester is offering
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  // Frame-level model: idle / loading k of 6 beats / p cycles after the last beat
  bit           m_busy;
  bit           m_own;
  bit           m_last;
  int           m_taken;
  int           m_post;
  bit           e_en;
  bit           e_col;
  bit           e_done;
  logic [W-1:0] e_data;
  logic [7:0]   e_ca;
  logic [7:0]   e_cb;
  logic [W-1:0] cur_rows[$];
  logic [W-1:0] exp_rows[$];

  // Observer of the memory's 0..15 counter and the rows it captures
  int           mc;
  logic [W-1:0] cap[$];

  typedef struct {
    bit va;
    bit vb;
    bit ra;
    bit rb;
  } vec_t;
  vec_t tbl[4];

  task automatic report(input string name, input string act, input string exp);
    failures++;
    $display("[TB] FAIL %s actual=%s expected=%s", name, act, exp);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) report(name, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic checkWord(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) report(name, $sformatf("%0h", act), $sformatf("%0h", exp));
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) report(name, $sformatf("%0d", act), $sformatf("%0d", exp));
  endtask

  task automatic modelReset();
    m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_taken = 0; m_post = 0;
    e_en = 1'b0; e_col = 1'b0; e_done = 1'b0; e_data = '0; e_ca = 8'd0; e_cb = 8'd0;
    cur_rows.delete();
    exp_rows.delete();
  endtask

  // Advance the model across one rising edge given this cycle's inputs
  task automatic modelStep(input bit rst, input bit va, input bit vb,
                           input logic [W-1:0] da, input logic [W-1:0] db);
    if (!rst) begin
      modelReset();
      return;
    end
    e_en   = 1'b0;
    e_done = 1'b0;
    if (!m_busy) begin
      if (va || vb) begin
        m_own   = (va && vb) ? !m_last : vb;
        m_busy  = 1'b1;
        m_taken = 0;
        m_post  = 0;
      end
    end else if (m_taken < 6) begin
      if (m_own ? vb : va) begin
        e_en   = 1'b1;
        e_data = m_own ? db : da;
        cur_rows.push_back(e_data);
        if (m_own) void'(qb.pop_front());
        else       void'(qa.pop_front());
        m_taken++;
        if (m_taken == 6) begin
          foreach (cur_rows[i]) exp_rows.push_back(cur_rows[i]);
          cur_rows.delete();
        end
      end
    end else begin
      if (m_post < 2) begin
        e_en   = 1'b1;
        e_data = '0;
      end
      if (m_post == 1) e_col = m_own;
      if (m_post == 8) e_done = 1'b1;
      if (m_post == 9) begin
        if (m_own) e_cb = e_cb + 8'd1;
        else       e_ca = e_ca + 8'd1;
        m_last = m_own;
        m_busy = 1'b0;
      end
      m_post++;
    end
  endtask

  task automatic checkOutput(input bit rst);
    if (rst) begin
      checkBit("a_ready", a_ready, m_busy && (m_taken < 6) && !m_own);
      checkBit("b_ready", b_ready, m_busy && (m_taken < 6) && m_own);
    end
    checkBit("mem_en", mem_en, e_en);
    checkWord("mem_data", mem_data, e_data);
    checkBit("col_owner", col_owner, e_col);
    checkBit("busy", busy, m_busy);
    checkBit("frame_done", frame_done, e_done);
    checkWord("cnt_a", W'(cnt_a), W'(e_ca));
    checkWord("cnt_b", W'(cnt_b), W'(e_cb));
  endtask

  // Memory counter observer: rows captured at counts 0-5 must equal the frame
  // the model expects, and enable must stay low through counts 8-15
  task automatic memCheck(input bit rst);
    if (!rst) begin
      mc = 0;
      cap.delete();
    end else if (mc >= 8) begin
      checkBit("mem_en_in_readout", mem_en, 1'b0);
      mc = (mc == 15) ? 0 : mc + 1;
    end else if (mem_en) begin
      if (mc < 6) cap.push_back(mem_data);
      mc++;
      if (mc == 8) begin
        if ((exp_rows.size() < 6) || (cap.size() != 6)) begin
          checks++;
          report("mem_frame", $sformatf("%0d rows", cap.size()),
                 $sformatf("%0d rows", exp_rows.size()));
          exp_rows.delete();
        end else begin
          for (int i = 0; i < 6; i++) checkWord("mem_row", cap[i], exp_rows.pop_front());
        end
        cap.delete();
      end
    end
  endtask

  // Drive one cycle at the falling edge, check, then step the model
  task automatic applyStimulus(input bit rst, input bit wa, input bit wb);
    rst_n   = rst;
    a_valid = wa && (qa.size() > 0);
    b_valid = wb && (qb.size() > 0);
    a_data  = (qa.size() > 0) ? qa[0] : '0;
    b_data  = (qb.size() > 0) ? qb[0] : '0;
    #1;
    checkOutput(rst);
    memCheck(rst);
    modelStep(rst, a_valid, b_valid, a_data, b_data);
    @(negedge clk);
  endtask

  task automatic pushRandFrame(input bit to_b);
    logic [95:0] r;
    for (int k = 0; k < 6; k++) begin
      r = {$urandom, $urandom, $urandom};
      if (to_b) qb.push_back(r[W-1:0]);
      else      qa.push_back(r[W-1:0]);
    end
  endtask

  // Main sequence
  initial begin
    int done_at;
    int dones;
    int ens;
    int first_b_ready;
    int first_b_en;
    int a_rdy_cycles;
    int b_rdy_cycles;
    int max_cnt_a;
    int done_cyc[$];
    bit done_own[$];

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    modelReset();
    mc = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    tbl[0] = '{va: 1'b1, vb: 1'b0, ra: 1'b1, rb: 1'b0};
    tbl[1] = '{va: 1'b0, vb: 1'b1, ra: 1'b0, rb: 1'b1};
    tbl[2] = '{va: 1'b1, vb: 1'b1, ra: 1'b1, rb: 1'b0};
    tbl[3] = '{va: 1'b0, vb: 1'b0, ra: 1'b0, rb: 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      qa.delete(); qb.delete();
      pushRandFrame(1'b0); pushRandFrame(1'b1);
      applyStimulus(1'b1, tbl[i].va, tbl[i].vb);
      checkBit("tbl_a_ready", a_ready, tbl[i].ra);
      checkBit("tbl_b_ready", b_ready, tbl[i].rb);
    end

    // Single A frame, rows 1..6 replicated per element
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    for (int k = 0; k < 6; k++) qa.push_back({6{12'(k + 1)}});
    done_at = -1; dones = 0; ens = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done) begin dones++; done_at = i; end
      if (mem_en) ens++;
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkInt("single_done_cycle", done_at, 16);
    checkInt("single_done_pulses", dones, 1);
    checkInt("single_en_beats", ens, 8);
    checkInt("single_cnt_a", int'(cnt_a), 1);
    checkBit("single_col_owner", col_owner, 1'b0);

    // A and B both requesting for four frames
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    pushRandFrame(1'b0); pushRandFrame(1'b0); pushRandFrame(1'b1); pushRandFrame(1'b1);
    a_rdy_cycles = 0; b_rdy_cycles = 0;
    for (int i = 0; i < 80; i++) begin
      if (frame_done) begin done_cyc.push_back(i); done_own.push_back(col_owner); end
      if (a_ready) a_rdy_cycles++;
      if (b_ready) b_rdy_cycles++;
      applyStimulus(1'b1, 1'b1, 1'b1);
    end
    checkInt("rr_frames", done_cyc.size(), 4);
    if (done_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++) checkInt("rr_period", done_cyc[k] - done_cyc[k-1], 17);
      for (int k = 0; k < 4; k++) checkBit("rr_owner", done_own[k], k[0]);
    end
    checkInt("rr_a_ready_cycles", a_rdy_cycles, 12);
    checkInt("rr_b_ready_cycles", b_rdy_cycles, 12);
    checkInt("rr_cnt_a", int'(cnt_a), 2);
    checkInt("rr_cnt_b", int'(cnt_b), 2);

    // A stalls for 3 cycles after beat 2
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    pushRandFrame(1'b0);
    done_at = -1; ens = 0;
    for (int i = 0; i < 24; i++) begin
      if (frame_done) done_at = i;
      if (mem_en) ens++;
      applyStimulus(1'b1, !((i >= 4) && (i <= 6)), 1'b0);
    end
    checkInt("stall_done_cycle", done_at, 19);
    checkInt("stall_en_beats", ens, 8);

    // B starts requesting during A's drain
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    pushRandFrame(1'b0); pushRandFrame(1'b1);
    first_b_ready = -1; first_b_en = -1;
    for (int i = 0; i < 40; i++) begin
      if (b_ready && (first_b_ready < 0)) first_b_ready = i;
      if (mem_en && (i > 12) && (first_b_en < 0)) first_b_en = i;
      applyStimulus(1'b1, 1'b1, i >= 10);
    end
    checkInt("late_b_first_ready", first_b_ready, 18);
    checkInt("late_b_first_en", first_b_en, 19);

    // Reset during the cycle that would accept beat 3
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    pushRandFrame(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkBit("midreset_busy", busy, 1'b0);
    checkBit("midreset_mem_en", mem_en, 1'b0);
    checkBit("midreset_a_ready", a_ready, 1'b0);
    qa.delete();
    for (int k = 0; k < 6; k++) qa.push_back({6{12'(12'hA00 + k)}});
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (frame_done) done_at = i;
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkInt("midreset_done_cycle", done_at, 16);
    checkInt("midreset_cnt_a", int'(cnt_a), 1);

    // 256 A-only frames wrap the A counter
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    for (int f = 0; f < 256; f++) pushRandFrame(1'b0);
    max_cnt_a = 0;
    for (int i = 0; i < 256 * 17 + 4; i++) begin
      if (int'(cnt_a) > max_cnt_a) max_cnt_a = int'(cnt_a);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkInt("wrap_max_cnt_a", max_cnt_a, 255);
    checkInt("wrap_cnt_a", int'(cnt_a), 0);
    checkInt("wrap_cnt_b", int'(cnt_b), 0);
    checkInt("wrap_queue_drained", qa.size(), 0);

    // Randomized traffic with occasional resets
    applyStimulus(1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    for (int f = 0; f < 12; f++) begin pushRandFrame(1'b0); pushRandFrame(1'b1); end
    for (int i = 0; i < 900; i++) begin
      applyStimulus($urandom_range(0, 399) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
